// File: rtl/atomik_uart_pkg.sv
// Shared UART definitions: bit-timing calculation, frame geometry, FSM encoding
// and frame byte helpers used by the telemetry transmitter.
package atomik_uart_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_BYTES       = 6;
    localparam int         BITS_PER_CHAR     = 10;   // start + 8 data + stop

    // Character-level FSM encoding, also exported as a debug output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Clock cycles per bit; integer division truncates. Result must be >= 2.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // XOR of the four word bytes.
    function automatic logic [7:0] word_checksum(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    // Byte at position idx of a frame: sync, word MSB-first, checksum.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [31:0] w,
                                              input logic [7:0]  chk,
                                              input logic [7:0]  sync);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = w[31:24];
            3'd2:    b = w[23:16];
            3'd3:    b = w[15:8];
            3'd4:    b = w[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_telemetry_tx_if.sv
// Word request channel into the telemetry transmitter.
// Handshake: a word transfers on a rising clk edge where tx_valid and tx_ready
// are both 1; tx_data is only sampled on that edge. tx_ready is 1 only while the
// transmitter is idle, and tx_valid seen while tx_ready is 0 is simply ignored.
interface uart_telemetry_tx_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// Single 8N1 character serialiser: baud counter, 10-bit shifter and the
// IDLE/START/DATA/STOP character FSM. A load restarts a character on that edge,
// which lets the caller chain characters with no gap. byte_done is high in the
// last cycle of the stop bit so the next load can land on the very next edge.
module uart_tx_byte
    import atomik_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       load,
    output logic       line,
    output logic       byte_done,
    output state_t     state
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W     = $clog2(BITS_PER_CHAR);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_CHAR - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BITS_PER_CHAR - 2);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] baud_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [9:0]       shift;
    logic             line_q;
    logic             line_d;
    logic             tick;

    // End of the current bit period while a character is in flight.
    assign tick  = (state_q != ST_IDLE) && (baud_cnt == CNT_LAST);
    assign line  = line_q;
    assign state = state_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: load always (re)starts a character.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_START;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_START: if (tick) state_d = ST_DATA;
                ST_DATA:  if (tick && bit_idx == DATA_LAST) state_d = ST_STOP;
                ST_STOP:  if (tick) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: completion strobe and next value of the registered line.
    always_comb begin
        byte_done = (state_q == ST_STOP) && tick;
        line_d    = line_q;
        if (load)      line_d = 1'b0;
        else if (tick) line_d = shift[1];
    end

    // Datapath: baud counter, bit index, shifter and the line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '1;
            line_q   <= 1'b1;
        end else begin
            line_q <= line_d;
            if (load) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                shift    <= {1'b1, data, 1'b0};
            end else if (tick) begin
                baud_cnt <= '0;
                bit_idx  <= (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
                shift    <= {1'b1, shift[9:1]};
            end else if (state_q != ST_IDLE) begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_telemetry_tx.sv
// Framed telemetry transmitter: each accepted 32-bit word goes out as six 8N1
// characters (sync, word MSB-first, XOR checksum) back to back on uart_tx.
// The top holds the word latch, checksum, byte sequencer and handshake; the
// character timing lives in uart_tx_byte.
module uart_telemetry_tx
    import atomik_uart_pkg::*;
#(
    parameter int         CLK_FREQ  = 27000000,
    parameter int         BAUD_RATE = 115200,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    uart_telemetry_tx_if.slave  bus,
    output logic                uart_tx,
    output logic                tx_busy,
    output logic                frame_done,
    output state_t              fsm_state
);

    // Must evaluate to at least 2 for the counter width to be meaningful.
    localparam int CPB = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

    logic        busy;
    logic [31:0] word_q;
    logic [7:0]  chk_q;
    logic [2:0]  byte_idx;
    logic        accept;
    logic        last_byte;
    logic        load;
    logic        byte_done;
    logic [7:0]  byte_sel;

    assign accept       = bus.tx_valid && !busy;
    assign bus.tx_ready = !busy;
    assign tx_busy      = busy;
    assign last_byte    = (byte_idx == 3'(FRAME_BYTES - 1));

    // Character load: sync on accept, otherwise the next byte as soon as the
    // previous stop bit ends, so the frame is one continuous bit stream.
    always_comb begin
        load     = accept || (byte_done && !last_byte);
        byte_sel = accept ? SYNC_BYTE
                          : frame_byte(byte_idx + 3'd1, word_q, chk_q, SYNC_BYTE);
    end

    // Word latch, byte sequencer, busy flag and end-of-frame strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            word_q     <= '0;
            chk_q      <= '0;
            byte_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                word_q   <= bus.tx_data;
                chk_q    <= word_checksum(bus.tx_data);
                byte_idx <= '0;
            end else if (byte_done) begin
                if (last_byte) begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    byte_idx   <= '0;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CPB)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .data      (byte_sel),
        .load      (load),
        .line      (uart_tx),
        .byte_done (byte_done),
        .state     (fsm_state)
    );

endmodule

// File: tb/tb_uart_telemetry_tx.sv
// Bench for uart_telemetry_tx at CPB=10: reset checks, a table of frames
// checked cycle by cycle against the expected bit stream, then a mid-frame
// reset sequence followed by a clean frame.
module tb_uart_telemetry_tx;
    import atomik_uart_pkg::*;

    localparam int CPB = 10;
    localparam int FRAME_CYC = 60 * CPB;

    logic   clk;
    logic   rst;
    logic   uart_tx;
    logic   tx_busy;
    logic   frame_done;
    state_t fsm_state;

    int tests_run;
    int tests_failed;

    uart_telemetry_tx_if bus();

    uart_telemetry_tx #(
        .CLK_FREQ  (1000000),
        .BAUD_RATE (100000),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .fsm_state  (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Checks one whole frame whose accept edge is the next rising edge.
    // Caller has already driven tx_valid/tx_data. Returns at #1 after the
    // frame_done edge.
    task automatic run_frame(input logic [31:0] word, input logic [7:0] chk,
                             input bit hold, input bit mid,
                             input logic [31:0] next_word, input string name);
        logic [7:0]  fb [6];
        logic [7:0]  dec [6];
        logic [59:0] ebits;
        int          bit_err;
        int          busy_err;
        int          fd_err;
        fb[0] = 8'hA5;
        fb[1] = word[31:24];
        fb[2] = word[23:16];
        fb[3] = word[15:8];
        fb[4] = word[7:0];
        fb[5] = chk;
        for (int by = 0; by < 6; by++) begin
            ebits[by*10] = 1'b0;
            for (int j = 0; j < 8; j++) ebits[by*10+1+j] = fb[by][j];
            ebits[by*10+9] = 1'b1;
            dec[by] = 8'h00;
        end
        bit_err  = 0;
        busy_err = 0;
        fd_err   = 0;
        @(posedge clk);
        #1;
        check($sformatf("%s start_at_accept", name), {31'd0, uart_tx}, 32'd0);
        check($sformatf("%s ready_low", name), {31'd0, bus.tx_ready}, 32'd0);
        if (!hold) bus.tx_valid = 1'b0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (uart_tx !== ebits[c/CPB]) bit_err++;
            if (tx_busy !== 1'b1) busy_err++;
            if (frame_done !== 1'b0) fd_err++;
            if ((c % CPB) == CPB/2 && ((c/CPB) % 10) >= 1 && ((c/CPB) % 10) <= 8)
                dec[c/(10*CPB)][((c/CPB) % 10) - 1] = uart_tx;
            if (mid && c == 250) begin
                bus.tx_data  = 32'hDEADBEEF;
                bus.tx_valid = 1'b1;
            end
            if (mid && !hold && c == 251) bus.tx_valid = 1'b0;
            if (hold && c == 300) bus.tx_data = next_word;
        end
        for (int by = 0; by < 6; by++)
            check($sformatf("%s byte%0d", name, by), {24'd0, dec[by]}, {24'd0, fb[by]});
        check($sformatf("%s bit_timing_errs", name), bit_err, 0);
        check($sformatf("%s busy_errs", name), busy_err, 0);
        check($sformatf("%s early_frame_done", name), fd_err, 0);
        @(posedge clk);
        #1;
        check($sformatf("%s frame_done", name), {31'd0, frame_done}, 32'd1);
        check($sformatf("%s ready_back", name), {31'd0, bus.tx_ready}, 32'd1);
        check($sformatf("%s fsm_idle", name), {30'd0, fsm_state}, {30'd0, ST_IDLE});
        check($sformatf("%s line_idle", name), {31'd0, uart_tx}, 32'd1);
    endtask

    // Quiet line for n cycles: high, idle, no stray frame_done.
    task automatic check_quiet(input int n, input string name);
        int errs;
        errs = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1 || frame_done !== 1'b0 || bus.tx_ready !== 1'b1) errs++;
        end
        check(name, errs, 0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  chk;
        bit          hold;
        bit          mid;
        logic [31:0] next_word;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit prev_hold;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{32'hAABBCCDD, 8'h00, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{32'h12345678, 8'h08, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{32'h00000001, 8'h01, 1'b1, 1'b0, 32'hFFFFFFFF};
        vecs[3] = '{32'hFFFFFFFF, 8'h00, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{32'h0BADF00D, 8'h5B, 1'b0, 1'b1, 32'h0};

        // Reset held
        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("rst tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst frame_done", {31'd0, frame_done}, 32'd0);
        check("rst fsm", {30'd0, fsm_state}, {30'd0, ST_IDLE});
        rst = 1'b0;
        check_quiet(3, "post_rst quiet");

        // Table of frames
        prev_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!prev_hold) begin
                bus.tx_data  = vecs[i].word;
                bus.tx_valid = 1'b1;
            end
            run_frame(vecs[i].word, vecs[i].chk, vecs[i].hold, vecs[i].mid,
                      vecs[i].next_word, $sformatf("vec%0d", i));
            if (!vecs[i].hold) check_quiet(20, $sformatf("vec%0d quiet", i));
            prev_hold = vecs[i].hold;
        end

        // Reset asserted during byte 2 of a frame
        bus.tx_data  = 32'h11223344;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        check("abort start", {31'd0, uart_tx}, 32'd0);
        repeat (255) @(posedge clk);
        #1;
        check("abort pre_rst line", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("abort line_high", {31'd0, uart_tx}, 32'd1);
        check("abort ready", {31'd0, bus.tx_ready}, 32'd1);
        check("abort busy", {31'd0, tx_busy}, 32'd0);
        check("abort fsm", {30'd0, fsm_state}, {30'd0, ST_IDLE});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_quiet(400, "abort no_frame_done");

        bus.tx_data  = 32'hCAFEF00D;
        bus.tx_valid = 1'b1;
        run_frame(32'hCAFEF00D, 8'hC9, 1'b0, 1'b0, 32'h0, "after_abort");
        check_quiet(10, "after_abort quiet");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
